irq_service_master: RTL
=======================

Name: irq_service_master

Overview:
- Hardware interrupt servicer and Avalon-MM master that drives the edge-capture PIO slave without CPU involvement.
- On reset it programs the slave's interrupt mask. On each irq it reads the edge-capture register, clears it, and timestamps the captured bit vector.
- Each event is pushed into a small FIFO, drained over a valid/ready stream to downstream logic such as a logger or DMA.

Parameters:
- DATA_WIDTH, 3: number of PIO input bits; the low DATA_WIDTH bits of readdata are used.
- MASK_INIT, 3'b111: value written to slave address 2 after reset.
- TS_WIDTH, 16: width of the free-running timestamp counter.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of two, at least 2.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous active-high reset.
- irq, in, 1: interrupt from the PIO slave, level.
- address, out, 2: Avalon-MM master address.
- chipselect, out, 1: master select.
- write_n, out, 1: active-low write strobe.
- writedata, out, 32: write data.
- readdata, in, 32: slave read data, registered one cycle after address.
- ev_valid, out, 1: FIFO head valid.
- ev_ready, in, 1: downstream accepts head.
- ev_data, out, DATA_WIDTH: captured edge bits of head entry.
- ev_time, out, TS_WIDTH: timestamp of head entry.
- overflow_cnt, out, 8: saturating count of events dropped because the FIFO was full.
- busy, out, 1: FSM not in IDLE.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset; all state changes occur on the rising edge of clk.
- Reset values:
  - address=0, chipselect=0, write_n=1, writedata=0.
  - ev_valid=0, ev_data=0, ev_time=0.
  - overflow_cnt=0, busy=1, because the FSM enters INIT.
  - Timestamp counter = 0; FIFO empty.
- Timestamp: increments by 1 every cycle and wraps modulo 2^TS_WIDTH. It is sampled into ts_hold on the cycle the FSM leaves IDLE.
- Bus rules:
  - No waitrequest. Each access is exactly one cycle with chipselect=1.
  - For a write, write_n=0.
  - For a read, write_n=1 and address is held one further cycle, because slave readdata reflects the previous cycle's address.
  - Outside accesses, chipselect=0, write_n=1, and address holds its last value.
- FSM states:
  - INIT: single cycle. address=2, chipselect=1, write_n=0, writedata=MASK_INIT zero-extended. Then IDLE.
  - IDLE: busy=0. If irq=1, go to RD_REQ and latch ts_hold.
  - RD_REQ: address=3, chipselect=1, write_n=1. Then RD_WAIT.
  - RD_WAIT: address stays 3, chipselect=0. Capture cap = readdata[DATA_WIDTH-1:0]. Then CLR.
  - CLR: address=3, chipselect=1, write_n=0, writedata=cap zero-extended. Go to PUSH.
  - PUSH: if cap != 0:
    - FIFO not full: write {cap, ts_hold}.
    - FIFO full: drop the event; overflow_cnt increments, saturating at 255.
    - Then go to GUARD.
  - If cap == 0 in PUSH (spurious irq), nothing is written; go to GUARD.
  - GUARD: one idle cycle so the slave's irq deasserts after the clear. Then IDLE.
- Minimum service time is 5 cycles from irq seen to IDLE. An irq still high in IDLE after GUARD (a new edge) starts a new service.
- An edge captured by the slave between RD_REQ and CLR is cleared by the CLR write and lost. This is an accepted slave limitation and is not detected.
- FIFO behaviour:
  - First-word-fall-through; ev_valid = not empty.
  - Pop happens when ev_valid and ev_ready.
  - A simultaneous push and pop when full is allowed: the pop frees the slot and the push succeeds, with no overflow.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap.
- Reset mid-operation: any state returns to INIT next cycle. Any in-flight bus access is aborted (chipselect=0 on the reset cycle). FIFO and overflow_cnt are cleared.

Test Plan:
- Release reset -> one cycle address=2, chipselect=1, write_n=0, writedata=7; then IDLE with chipselect=0, busy=0.
- irq high at timestamp 0x0010, readdata=3'b101 the cycle after RD_REQ -> read at address 3, then write of 5 to address 3; ev_valid=1, ev_data=5, ev_time=0x0010, with ev_ready=0.
- Five events with ev_ready=0 and FIFO_DEPTH=4 -> four entries held in order, overflow_cnt=1; raising ev_ready drains them in arrival order.
- FIFO full, push cycle coincides with ev_ready=1 -> no drop, overflow_cnt unchanged, occupancy stays 4.
- irq high, readdata=0 -> read and clear still issued; ev_valid stays 0 and overflow_cnt stays 0.
- reset asserted while in CLR -> next cycle chipselect=0, then INIT write to address 2; FIFO empty and overflow_cnt=0.

Source files
------------

// File: rtl/irq_service_master.sv
// irq_service_master
// Services interrupts from an edge-capture PIO slave over Avalon-MM with no CPU involvement.
// After reset it writes the interrupt mask (address 2). On every irq it reads the edge-capture
// register (address 3), writes the captured bits back to clear them, and pushes the captured
// bits together with a timestamp into a small first-word-fall-through FIFO.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_irq                   level interrupt from the PIO slave
//   o_address, o_chipselect, o_write_n, o_writedata, i_readdata
//                           Avalon-MM master (no waitrequest, readdata one cycle after address)
//   o_ev_valid, i_ev_ready, o_ev_data, o_ev_time
//                           event stream (FIFO head)
//   o_overflow_cnt          saturating count of events dropped on a full FIFO
//   o_busy                  servicer is not idle
module irq_service_master #(
  parameter int unsigned           DATA_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] MASK_INIT  = 3'b111,
  parameter int unsigned           TS_WIDTH   = 16,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_irq,
  output logic [1:0]            o_address,
  output logic                  o_chipselect,
  output logic                  o_write_n,
  output logic [31:0]           o_writedata,
  input  logic [31:0]           i_readdata,
  output logic                  o_ev_valid,
  input  logic                  i_ev_ready,
  output logic [DATA_WIDTH-1:0] o_ev_data,
  output logic [TS_WIDTH-1:0]   o_ev_time,
  output logic [7:0]            o_overflow_cnt,
  output logic                  o_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_WIDTH + TS_WIDTH;

  // StRst is the cycle after reset with the bus quiet; StInit issues the mask write.
  typedef enum logic [2:0] {
    StRst, StInit, StIdle, StRdReq, StRdWait, StClr, StPush, StGuard
  } state_e;

  state_e                r_state;
  logic [1:0]            r_address;
  logic                  r_chipselect;
  logic                  r_write_n;
  logic [31:0]           r_writedata;
  logic                  r_busy;
  logic [TS_WIDTH-1:0]   r_ts;
  logic [TS_WIDTH-1:0]   r_ts_hold;
  logic [DATA_WIDTH-1:0] r_cap;
  logic [7:0]            r_ovf;
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_event;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;
  logic          w_unused_rdata;

  // Only the low DATA_WIDTH bits of readdata carry edge-capture bits.
  assign w_unused_rdata = ^i_readdata[31:DATA_WIDTH];

  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = !w_empty && i_ev_ready;
    w_event = (r_state == StPush) && (r_cap != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    w_push  = w_event && (!w_full || w_pop);
    w_drop  = w_event && w_full && !w_pop;
    w_head  = r_mem[r_rd_ptr[AW-1:0]];
  end

  // Free-running timestamp.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // FIFO pointers; extra MSB distinguishes full from empty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r_cap, r_ts_hold};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ovf <= '0;
    end else if (w_drop && (r_ovf != 8'hff)) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

  // Servicing FSM; bus outputs are registered so they line up with the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StRst;
      r_address    <= '0;
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      r_writedata  <= '0;
      r_busy       <= 1'b1;
      r_ts_hold    <= '0;
      r_cap        <= '0;
    end else begin
      case (r_state)
        StRst: begin
          r_state      <= StInit;
          r_address    <= 2'd2;
          r_chipselect <= 1'b1;
          r_write_n    <= 1'b0;
          r_writedata  <= 32'(MASK_INIT);
        end
        StInit: begin
          r_state      <= StIdle;
          r_chipselect <= 1'b0;
          r_write_n    <= 1'b1;
          r_busy       <= 1'b0;
        end
        StIdle: begin
          if (i_irq) begin
            r_state      <= StRdReq;
            r_ts_hold    <= r_ts;
            r_address    <= 2'd3;
            r_chipselect <= 1'b1;
            r_write_n    <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        StRdReq: begin
          // Address stays at 3 so readdata in the next cycle is the edge-capture register.
          r_state      <= StRdWait;
          r_chipselect <= 1'b0;
        end
        StRdWait: begin
          r_state      <= StClr;
          r_cap        <= i_readdata[DATA_WIDTH-1:0];
          r_chipselect <= 1'b1;
          r_write_n    <= 1'b0;
          r_writedata  <= 32'(i_readdata[DATA_WIDTH-1:0]);
        end
        StClr: begin
          r_state      <= StPush;
          r_chipselect <= 1'b0;
          r_write_n    <= 1'b1;
        end
        StPush: begin
          r_state <= StGuard;
        end
        StGuard: begin
          // Gives the slave a cycle to drop irq after the clear.
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StRst;
        end
      endcase
    end
  end

  assign o_address      = r_address;
  assign o_chipselect   = r_chipselect;
  assign o_write_n      = r_write_n;
  assign o_writedata    = r_writedata;
  assign o_busy         = r_busy;
  assign o_overflow_cnt = r_ovf;
  assign o_ev_valid     = !w_empty;
  assign o_ev_data      = w_empty ? '0 : w_head[EW-1:TS_WIDTH];
  assign o_ev_time      = w_empty ? '0 : w_head[TS_WIDTH-1:0];

endmodule
